// File: rtl/pim_pkg.sv
// Shared definitions for the PIM controller.
// Contents: default register addresses, the sequencer state enum,
// and the bit positions of the PIM_CTRL status word.
package pim_pkg;

  localparam logic [31:0] PIM_CTRL_ADDR         = 32'h4000_0010;
  localparam logic [31:0] PIM_R_ADDR            = 32'h4000_0020;
  localparam logic [31:0] PIM_W_WEIGHT_ADDR     = 32'h4000_0040;
  localparam logic [31:0] PIM_W_ACTIVATION_ADDR = 32'h4000_0080;

  // PIM_CTRL write bits
  localparam int unsigned CB_START = 0;
  localparam int unsigned CB_CLEAR = 1;

  // PIM_CTRL status bits
  localparam int unsigned SB_BUSY     = 0;
  localparam int unsigned SB_DONE     = 1;
  localparam int unsigned SB_AOVF     = 2;
  localparam int unsigned SB_REMPTY   = 3;
  localparam int unsigned SB_RUNF     = 4;
  localparam int unsigned SB_WERR     = 5;
  localparam int unsigned SB_ACNT_LSB = 8;
  localparam int unsigned SB_RCNT_LSB = 16;
  localparam int unsigned SB_CNT_W    = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPTURE
  } pim_state_e;

endpackage

// File: rtl/pim_sync_fifo.sv
// Single-clock FIFO with occupancy count and same-cycle push/pop.
// Ports: clk/rst_n, clear (synchronous flush), push/din, pop,
//        head_c (current head word), full_c/empty_c, count (registered).
// A push into a full FIFO or a pop from an empty FIFO is ignored.
module pim_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full_c    = (count == CW'(DEPTH));
  assign empty_c   = (count == '0);
  assign push_ok_c = push && !full_c;
  assign pop_ok_c  = pop && !empty_c;
  assign head_c    = mem[rptr];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok_c) wptr <= wptr + AW'(1);
      if (pop_ok_c)  rptr <= rptr + AW'(1);
      case ({push_ok_c, pop_ok_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pim_ctrl.sv
// Memory-mapped controller between the system bus PIM port and the PIM macro.
// Ports: i_clk/i_rst_n; bus slave i_pim_addr/write/read/size/din, o_pim_dout;
//        macro side o_mac_we/row/wdata (weight load), o_mac_act/o_mac_start
//        (evaluation launch), i_mac_result (valid MAC_CYCLES after start).
module pim_ctrl
  import pim_pkg::*;
#(
  parameter int unsigned     XLEN             = 32,
  parameter logic [XLEN-1:0] PIM_CTRL         = XLEN'(PIM_CTRL_ADDR),
  parameter logic [XLEN-1:0] PIM_R            = XLEN'(PIM_R_ADDR),
  parameter logic [XLEN-1:0] PIM_W_WEIGHT     = XLEN'(PIM_W_WEIGHT_ADDR),
  parameter logic [XLEN-1:0] PIM_W_ACTIVATION = XLEN'(PIM_W_ACTIVATION_ADDR),
  parameter int unsigned     NUM_ROWS         = 64,
  parameter int unsigned     FIFO_DEPTH       = 16,
  parameter int unsigned     MAC_CYCLES       = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [XLEN-1:0]             i_pim_addr,
  input  logic                        i_pim_write,
  input  logic                        i_pim_read,
  input  logic [3:0]                  i_pim_size,
  input  logic [XLEN-1:0]             i_pim_din,
  output logic [XLEN-1:0]             o_pim_dout,
  output logic                        o_mac_we,
  output logic [$clog2(NUM_ROWS)-1:0] o_mac_row,
  output logic [XLEN-1:0]             o_mac_wdata,
  output logic [XLEN-1:0]             o_mac_act,
  output logic                        o_mac_start,
  input  logic [XLEN-1:0]             i_mac_result
);

  localparam int unsigned ROW_W = $clog2(NUM_ROWS);
  localparam int unsigned CNT_W = $clog2(MAC_CYCLES + 1);
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;

  pim_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [ROW_W-1:0] wptr_q;
  logic             done_q, aovf_q, runf_q, werr_q;

  logic             wr_ctrl_c, wr_weight_c, wr_act_c, rd_ctrl_c, rd_res_c;
  logic             start_c, clear_c, busy_c;
  logic             act_pop_c, res_push_c, set_done_c;
  logic [XLEN-1:0]  act_head_c, res_head_c, status_c;
  logic             act_full_c, act_empty_c, res_full_c, res_empty_c;
  logic [FCW-1:0]   act_count, res_count;
  logic             unused_size;

  // Byte enables carry no meaning on this full-word port
  assign unused_size = ^i_pim_size;

  // Exact-address decode
  assign wr_ctrl_c   = i_pim_write && (i_pim_addr == PIM_CTRL);
  assign wr_weight_c = i_pim_write && (i_pim_addr == PIM_W_WEIGHT);
  assign wr_act_c    = i_pim_write && (i_pim_addr == PIM_W_ACTIVATION);
  assign rd_ctrl_c   = i_pim_read  && (i_pim_addr == PIM_CTRL);
  assign rd_res_c    = i_pim_read  && (i_pim_addr == PIM_R);

  // Clear wins over start in the same write
  assign clear_c = wr_ctrl_c && i_pim_din[CB_CLEAR];
  assign start_c = wr_ctrl_c && i_pim_din[CB_START] && !i_pim_din[CB_CLEAR];
  assign busy_c  = (state_q != S_IDLE);

  pim_sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH), .CW(FCW)) u_act_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clear   (clear_c),
    .push    (wr_act_c),
    .din     (i_pim_din),
    .pop     (act_pop_c),
    .head_c  (act_head_c),
    .full_c  (act_full_c),
    .empty_c (act_empty_c),
    .count   (act_count)
  );

  pim_sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH), .CW(FCW)) u_res_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clear   (clear_c),
    .push    (res_push_c),
    .din     (i_mac_result),
    .pop     (rd_res_c),
    .head_c  (res_head_c),
    .full_c  (res_full_c),
    .empty_c (res_empty_c),
    .count   (res_count)
  );

  // Status word as seen before the current edge
  always_comb begin
    status_c                               = '0;
    status_c[SB_BUSY]                      = busy_c;
    status_c[SB_DONE]                      = done_q;
    status_c[SB_AOVF]                      = aovf_q;
    status_c[SB_REMPTY]                    = res_empty_c;
    status_c[SB_RUNF]                      = runf_q;
    status_c[SB_WERR]                      = werr_q;
    status_c[SB_ACNT_LSB +: SB_CNT_W]      = SB_CNT_W'(act_count);
    status_c[SB_RCNT_LSB +: SB_CNT_W]      = SB_CNT_W'(res_count);
  end

  // Sequencer state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Sequencer next state and FIFO handshakes
  always_comb begin
    state_d    = state_q;
    act_pop_c  = 1'b0;
    res_push_c = 1'b0;
    set_done_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_c && !act_empty_c) state_d = S_LOAD;
      end
      S_LOAD: begin
        act_pop_c = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Stall here while the result FIFO has no room
        if (!res_full_c) begin
          res_push_c = 1'b1;
          if (act_empty_c) begin
            state_d    = S_IDLE;
            set_done_c = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear_c) begin
      state_d    = S_IDLE;
      act_pop_c  = 1'b0;
      res_push_c = 1'b0;
      set_done_c = 1'b0;
    end
  end

  // Datapath, macro-facing outputs, sticky flags and bus read data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q       <= '0;
      wptr_q      <= '0;
      done_q      <= 1'b0;
      aovf_q      <= 1'b0;
      runf_q      <= 1'b0;
      werr_q      <= 1'b0;
      o_pim_dout  <= '0;
      o_mac_we    <= 1'b0;
      o_mac_row   <= '0;
      o_mac_wdata <= '0;
      o_mac_act   <= '0;
      o_mac_start <= 1'b0;
    end else begin
      o_mac_we    <= 1'b0;
      o_mac_start <= act_pop_c;
      if (act_pop_c) o_mac_act <= act_head_c;

      if (state_q == S_LOAD)      cnt_q <= CNT_W'(MAC_CYCLES);
      else if (state_q == S_WAIT) cnt_q <= cnt_q - CNT_W'(1);

      if (wr_weight_c) begin
        if (busy_c) begin
          werr_q <= 1'b1;
        end else begin
          o_mac_we    <= 1'b1;
          o_mac_row   <= wptr_q;
          o_mac_wdata <= i_pim_din;
          wptr_q      <= wptr_q + ROW_W'(1);
        end
      end

      if (wr_act_c && act_full_c) aovf_q <= 1'b1;

      if (i_pim_read) begin
        if (rd_ctrl_c)                    o_pim_dout <= status_c;
        else if (rd_res_c && !res_empty_c) o_pim_dout <= res_head_c;
        else                              o_pim_dout <= '0;
      end
      if (rd_res_c && res_empty_c) runf_q <= 1'b1;

      // Empty-FIFO start completes immediately
      if (set_done_c)                done_q <= 1'b1;
      else if (start_c && !busy_c)   done_q <= act_empty_c;

      if (clear_c) begin
        wptr_q <= '0;
        done_q <= 1'b0;
        aovf_q <= 1'b0;
        runf_q <= 1'b0;
        werr_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pim_ctrl.sv
// Scoreboard bench for pim_ctrl: stimulus queues expected weight pulses,
// evaluation launches and read data; a monitor pops and compares them.
module tb_pim_ctrl;

  localparam logic [31:0] A_CTRL = 32'h4000_0010;
  localparam logic [31:0] A_R    = 32'h4000_0020;
  localparam logic [31:0] A_WGT  = 32'h4000_0040;
  localparam logic [31:0] A_ACT  = 32'h4000_0080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pim_addr = '0;
  logic        pim_write = 1'b0;
  logic        pim_read = 1'b0;
  logic [3:0]  pim_size = 4'hF;
  logic [31:0] pim_din = '0;
  logic [31:0] pim_dout;
  logic        mac_we;
  logic [5:0]  mac_row;
  logic [31:0] mac_wdata;
  logic [31:0] mac_act;
  logic        mac_start;
  logic [31:0] mac_result;

  int n_tests = 0;
  int n_fail  = 0;
  int we_seen = 0, start_seen = 0;
  int we_exp_total = 0, start_exp_total = 0;
  logic rd_pend = 1'b0;

  logic [5:0]  we_row_q  [$];
  logic [31:0] we_data_q [$];
  logic [31:0] start_q   [$];
  logic [31:0] rd_q      [$];
  string       rd_nm_q   [$];

  always #5 clk = ~clk;

  // Macro model: result is the activation doubled
  assign mac_result = {mac_act[30:0], 1'b0};

  pim_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pim_addr   (pim_addr),
    .i_pim_write  (pim_write),
    .i_pim_read   (pim_read),
    .i_pim_size   (pim_size),
    .i_pim_din    (pim_din),
    .o_pim_dout   (pim_dout),
    .o_mac_we     (mac_we),
    .o_mac_row    (mac_row),
    .o_mac_wdata  (mac_wdata),
    .o_mac_act    (mac_act),
    .o_mac_start  (mac_start),
    .i_mac_result (mac_result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pim_addr = a; pim_din = d; pim_write = 1'b1;
    @(posedge clk); #1;
    pim_write = 1'b0; pim_addr = '0; pim_din = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    pim_addr = a; pim_read = 1'b1;
    rd_q.push_back(exp);
    rd_nm_q.push_back(nm);
    @(posedge clk); #1;
    pim_read = 1'b0; pim_addr = '0;
  endtask

  task automatic push_weight(input logic [31:0] d, input logic [5:0] row);
    we_row_q.push_back(row);
    we_data_q.push_back(d);
    we_exp_total++;
    bus_write(A_WGT, d);
  endtask

  task automatic push_act(input logic [31:0] d, input bit launched);
    if (launched) begin
      start_q.push_back(d);
      start_exp_total++;
    end
    bus_write(A_ACT, d);
  endtask

  // Remember which cycles carried a read strobe
  always @(posedge clk) rd_pend <= pim_read && rst_n;

  // Monitor: compare every DUT presentation against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (mac_we) begin
        we_seen++;
        if (we_row_q.size() == 0) begin
          check("unexpected_we", mac_wdata, 32'hxxxx_xxxx);
        end else begin
          check("we_row", 32'(mac_row), 32'(we_row_q.pop_front()));
          check("we_data", mac_wdata, we_data_q.pop_front());
        end
      end
      if (mac_start) begin
        start_seen++;
        if (start_q.size() == 0) check("unexpected_start", mac_act, 32'hxxxx_xxxx);
        else                     check("mac_act", mac_act, start_q.pop_front());
      end
      if (rd_pend) begin
        if (rd_q.size() == 0) check("unexpected_read", pim_dout, 32'hxxxx_xxxx);
        else                  check(rd_nm_q.pop_front(), pim_dout, rd_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", pim_dout, 32'h0);
    check("rst_we", 32'(mac_we), 32'h0);
    check("rst_start", 32'(mac_start), 32'h0);
    check("rst_row", 32'(mac_row), 32'h0);
    check("rst_act", mac_act, 32'h0);
    rst_n = 1'b1;
    bus_read(A_CTRL, 32'h0000_0008, "rst_status");

    // Weight rows and wrap
    for (int i = 0; i < 4; i++) push_weight(32'hA0 + 32'(i), 6'(i));
    for (int i = 0; i < 64; i++) push_weight(32'h100 + 32'(i), 6'((4 + i) % 64));

    // Basic compute: 3 activations, 30 busy cycles
    push_act(32'd1, 1'b1);
    push_act(32'd2, 1'b1);
    push_act(32'd3, 1'b1);
    bus_read(A_CTRL, 32'h0000_0308, "pre_start_status");
    bus_write(A_CTRL, 32'h1);
    repeat (28) @(posedge clk);
    bus_read(A_CTRL, 32'h0002_0001, "last_busy_status");
    bus_read(A_CTRL, 32'h0003_0002, "done_status");
    bus_read(A_R, 32'd2, "res0");
    bus_read(A_R, 32'd4, "res1");
    bus_read(A_R, 32'd6, "res2");
    bus_read(A_R, 32'd0, "res_underflow");
    bus_read(A_CTRL, 32'h0000_001A, "runf_status");
    bus_read(32'h4000_0014, 32'h0, "unmapped");

    // Activation overflow, then fill the result FIFO
    bus_write(A_CTRL, 32'h2);
    for (int i = 0; i < 17; i++) push_act(32'h10 + 32'(i), i < 16);
    bus_read(A_CTRL, 32'h0000_100C, "aovf_status");
    bus_write(A_CTRL, 32'h1);
    repeat (170) @(posedge clk);
    bus_read(A_CTRL, 32'h0010_0006, "res_full_status");

    // Result-full stall in CAPTURE
    push_act(32'h55, 1'b1);
    bus_write(A_CTRL, 32'h1);
    repeat (15) @(posedge clk);
    bus_read(A_CTRL, 32'h0010_0005, "stall_status");
    bus_read(A_R, 32'h20, "stall_pop");
    bus_read(A_CTRL, 32'h0010_0006, "stall_released");

    // Weight write and start while busy
    bus_write(A_CTRL, 32'h2);
    push_act(32'd7, 1'b1);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_WGT, 32'hDEAD);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, 32'h0000_0029, "werr_status");
    repeat (20) @(posedge clk);
    bus_read(A_CTRL, 32'h0001_0022, "werr_done_status");
    bus_read(A_R, 32'd14, "werr_res");

    // Clear during WAIT
    bus_write(A_CTRL, 32'h2);
    push_weight(32'hB0, 6'd0);
    push_weight(32'hB1, 6'd1);
    push_act(32'd9, 1'b1);
    bus_write(A_CTRL, 32'h1);
    repeat (2) @(posedge clk);
    bus_write(A_CTRL, 32'h2);
    bus_read(A_CTRL, 32'h0000_0008, "clear_status");
    push_weight(32'hB2, 6'd0);
    repeat (15) @(posedge clk);
    bus_read(A_CTRL, 32'h0000_0008, "clear_no_result");

    // Async reset mid-WAIT
    push_act(32'h33, 1'b1);
    bus_write(A_CTRL, 32'h1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_dout", pim_dout, 32'h0);
    check("arst_wdata", mac_wdata, 32'h0);
    check("arst_act", mac_act, 32'h0);
    check("arst_row", 32'(mac_row), 32'h0);
    check("arst_start", 32'(mac_start), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    bus_read(A_CTRL, 32'h0000_0008, "arst_status");
    bus_read(A_R, 32'h0, "arst_no_result");
    bus_read(A_CTRL, 32'h0000_0018, "arst_runf");

    // Totals and leftovers
    repeat (4) @(posedge clk);
    check("we_pulse_count", 32'(we_seen), 32'(we_exp_total));
    check("start_pulse_count", 32'(start_seen), 32'(start_exp_total));
    check("pending_expectations", 32'(we_row_q.size() + start_q.size() + rd_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
